// File: rtl/soc_pkg.sv
// soc_pkg: shared SoC bus definitions.
//   WB_DW / WB_AW      : Wishbone data and address widths.
//   wb_slave_state_t   : FSM encoding shared by Wishbone slaves.
package soc_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } wb_slave_state_t;

endpackage : soc_pkg

// File: rtl/wb_sram_slave_if.sv
// wb_sram_slave_if: Wishbone classic bus bundle.
// Signal names follow the slave's point of view (_i into the slave, _o out of it).
//   master modport: drives cyc/stb/adr/sel/dat_i/we, receives dat_o/ack/err/rty.
//   slave  modport: the mirror image.
interface wb_sram_slave_if;
  import soc_pkg::*;

  logic              cyc_i;
  logic              stb_i;
  logic [WB_AW-1:0]  adr_i;
  logic [3:0]        sel_i;
  logic [WB_DW-1:0]  dat_i;
  logic              we_i;
  logic [WB_DW-1:0]  dat_o;
  logic              ack_o;
  logic              err_o;
  logic              rty_o;

  modport master (
    output cyc_i, stb_i, adr_i, sel_i, dat_i, we_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, adr_i, sel_i, dat_i, we_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface : wb_sram_slave_if

// File: rtl/sram_sp.sv
// sram_sp: behavioural single-port RAM, 32-bit words, per-byte write mask,
// registered read (one cycle latency).
//   clk_i   : clock
//   we_i    : write enable
//   be_i    : byte enables, bit n covers wdata_i[8n+7:8n]
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (old contents on a same-cycle write)
module sram_sp
  import soc_pkg::*;
#(
  parameter int WORDS = 4096
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [$clog2(WORDS)-1:0] addr_i,
  input  logic [WB_DW-1:0]         wdata_i,
  output logic [WB_DW-1:0]         rdata_o
);

  logic [WB_DW-1:0] mem [WORDS];

  // Byte-masked write and registered read of the addressed word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_o <= mem[addr_i];
  end

endmodule : sram_sp

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone classic slave in front of a byte-maskable SRAM.
//   clk_i  : bus clock
//   rst_ni : asynchronous active-low reset
//   wb     : Wishbone slave port (cyc/stb/adr/sel/dat/we in, dat/ack/err/rty out)
// Writes commit in the accept cycle; acks follow after WAIT_STATES extra cycles.
// Out-of-window strobes get a one-cycle err (ERR_ENABLE=1) or are ignored.
module wb_sram_slave
  import soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          SIZE_BYTES   = 16384,
  parameter int          WAIT_STATES  = 0,
  parameter bit          ERR_ENABLE   = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  wb_sram_slave_if.slave  wb
);

  localparam int         WORDS  = SIZE_BYTES / 4;
  localparam int         AW     = $clog2(WORDS);
  localparam logic [3:0] WAIT_L = 4'(WAIT_STATES);

  wb_slave_state_t  state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             we_q, we_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [31:0]      offset_s;
  logic             hit_s;
  logic             req_s;
  logic             accept_s;
  logic [AW-1:0]    idx_s;
  logic             ram_we_s;
  logic [AW-1:0]    ram_addr_s;
  logic [WB_DW-1:0] ram_rdata_s;
  logic             unused_offset_s;

  // Address decode against the window.
  assign offset_s        = wb.adr_i - BASE_ADDRESS;
  assign hit_s           = (wb.adr_i >= BASE_ADDRESS) && (offset_s < 32'(SIZE_BYTES));
  assign idx_s           = offset_s[AW+1:2];
  assign req_s           = wb.cyc_i && wb.stb_i;
  assign accept_s        = req_s && hit_s && (state_q == ST_IDLE);
  assign unused_offset_s = ^{offset_s[1:0], offset_s[31:AW+2]};

  // The RAM is only written in the accept cycle; after that the latched index
  // holds the read address so adr_i is free to change during wait states.
  assign ram_we_s   = accept_s && wb.we_i;
  assign ram_addr_s = (state_q == ST_IDLE) ? idx_s : idx_q;

  sram_sp #(.WORDS(WORDS)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we_s),
    .be_i    (wb.sel_i),
    .addr_i  (ram_addr_s),
    .wdata_i (wb.dat_i),
    .rdata_o (ram_rdata_s)
  );

  // Next-state, counter and termination logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          idx_d = idx_s;
          we_d  = wb.we_i;
          cnt_d = WAIT_L;
          if (WAIT_L != 4'd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
          end
        end else if (req_s && !hit_s && ERR_ENABLE) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!wb.cyc_i) begin
          // Master abandoned the cycle: no termination, write already done.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // ack_q is high exactly while in RESP, so it gates the read bus to zero otherwise.
  assign wb.dat_o = (ack_q && !we_q) ? ram_rdata_s : 32'h0000_0000;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.rty_o = 1'b0;

endmodule : wb_sram_slave

// File: tb/tb_wb_sram_slave.sv
// Bench for wb_sram_slave: four instances (WAIT 0 / WAIT 3 / WAIT 0 no-err /
// WAIT 5) share one master driver; a target select routes cyc/stb to one of them.
module tb_wb_sram_slave;
  import soc_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SIZE = 16384;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;

  logic clk;
  logic rst_ni;
  int   tgt;
  logic m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat;

  int checks = 0;
  int errors = 0;
  int waits [4] = '{0, 3, 0, 5};
  logic [31:0] model_mem [int];
  logic [31:0] sb_q [$];

  wb_sram_slave_if if0 ();
  wb_sram_slave_if if1 ();
  wb_sram_slave_if if2 ();
  wb_sram_slave_if if3 ();

  wb_sram_slave #(.BASE_ADDRESS(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(0), .ERR_ENABLE(1'b1))
    u0 (.clk_i(clk), .rst_ni(rst_ni), .wb(if0));
  wb_sram_slave #(.BASE_ADDRESS(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(3), .ERR_ENABLE(1'b1))
    u1 (.clk_i(clk), .rst_ni(rst_ni), .wb(if1));
  wb_sram_slave #(.BASE_ADDRESS(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(0), .ERR_ENABLE(1'b0))
    u2 (.clk_i(clk), .rst_ni(rst_ni), .wb(if2));
  wb_sram_slave #(.BASE_ADDRESS(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(5), .ERR_ENABLE(1'b1))
    u3 (.clk_i(clk), .rst_ni(rst_ni), .wb(if3));

  assign if0.cyc_i = m_cyc & (tgt == 0);
  assign if1.cyc_i = m_cyc & (tgt == 1);
  assign if2.cyc_i = m_cyc & (tgt == 2);
  assign if3.cyc_i = m_cyc & (tgt == 3);
  assign if0.stb_i = m_stb & (tgt == 0);
  assign if1.stb_i = m_stb & (tgt == 1);
  assign if2.stb_i = m_stb & (tgt == 2);
  assign if3.stb_i = m_stb & (tgt == 3);
  assign {if0.adr_i, if1.adr_i, if2.adr_i, if3.adr_i} = {4{m_adr}};
  assign {if0.dat_i, if1.dat_i, if2.dat_i, if3.dat_i} = {4{m_dat}};
  assign {if0.sel_i, if1.sel_i, if2.sel_i, if3.sel_i} = {4{m_sel}};
  assign {if0.we_i,  if1.we_i,  if2.we_i,  if3.we_i}  = {4{m_we}};

  // Route the selected slave's outputs back to the master side.
  always_comb begin
    case (tgt)
      1:       begin s_ack = if1.ack_o; s_err = if1.err_o; s_rty = if1.rty_o; s_dat = if1.dat_o; end
      2:       begin s_ack = if2.ack_o; s_err = if2.err_o; s_rty = if2.rty_o; s_dat = if2.dat_o; end
      3:       begin s_ack = if3.ack_o; s_err = if3.err_o; s_rty = if3.rty_o; s_dat = if3.dat_o; end
      default: begin s_ack = if0.ack_o; s_err = if0.err_o; s_rty = if0.rty_o; s_dat = if0.dat_o; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(SIZE));
  endfunction

  function automatic int mkey(input int t, input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return t * 65536 + int'(off);
  endfunction

  function automatic logic [31:0] model_rd(input int t, input logic [31:0] a);
    int k;
    k = mkey(t, a);
    if (model_mem.exists(k)) return model_mem[k];
    return 32'h0000_0000;
  endfunction

  task automatic model_wr(input int t, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] w;
    w = model_rd(t, a);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    end
    model_mem[mkey(t, a)] = w;
  endtask

  task automatic bus_idle();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0;
  endtask

  // One bus transfer. Cycle 0 is the cycle the strobe is first presented.
  task automatic xfer(input int t, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input int kind, input int garble_at,
                      input logic [31:0] garble_adr, input int drop_at, input string nm);
    int exp_n;
    int last_n;
    logic [31:0] exp_d;
    exp_n  = (kind == K_ACK) ? 1 + waits[t] : 1;
    last_n = (kind == K_NONE) ? 20 : exp_n;
    @(posedge clk); #1;
    tgt = t; m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_sel = s; m_dat = d;
    if (kind == K_ACK) sb_q.push_back(w ? 32'h0000_0000 : model_rd(t, a));
    if (w && in_win(a)) model_wr(t, a, s, d);
    for (int n = 1; n <= last_n; n++) begin
      @(posedge clk); #1;
      if (kind == K_ACK && n == exp_n) begin
        exp_d = sb_q.pop_front();
        checks++;
        if (s_ack !== 1'b1) begin
          errors++; $display("FAIL %s ack cycle %0d: got %b expected 1", nm, n, s_ack);
        end
        checks++;
        if (s_dat !== exp_d) begin
          errors++; $display("FAIL %s data: got %h expected %h", nm, s_dat, exp_d);
        end
      end else begin
        checks++;
        if (s_ack !== 1'b0) begin
          errors++; $display("FAIL %s stray ack cycle %0d: got %b expected 0", nm, n, s_ack);
        end
        checks++;
        if (s_dat !== 32'h0000_0000) begin
          errors++; $display("FAIL %s idle dat_o cycle %0d: got %h expected 0", nm, n, s_dat);
        end
      end
      checks++;
      if (s_err !== ((kind == K_ERR && n == exp_n) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL %s err cycle %0d: got %b", nm, n, s_err);
      end
      if (n == garble_at) m_adr = garble_adr;
      if (n == drop_at) begin m_cyc = 1'b0; m_stb = 1'b0; end
    end
    bus_idle();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus_idle();
    tgt = 0;
    #12;
    checks++;
    if ({s_ack, s_err, s_rty} !== 3'b000 || s_dat !== 32'h0) begin
      errors++; $display("FAIL reset outputs: got %b/%h expected 000/0", {s_ack, s_err, s_rty}, s_dat);
    end
    checks++;
    if (u0.state_q !== ST_IDLE || u0.cnt_q !== 4'd0) begin
      errors++; $display("FAIL reset state: got %0d/%0d expected IDLE/0", u0.state_q, u0.cnt_q);
    end
    #5 rst_ni = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    tgt = 1; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = BASE; m_sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (u1.state_q !== ST_WAIT) begin
      errors++; $display("FAIL rst_mid pre-state: got %0d expected WAIT", u1.state_q);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({s_ack, s_err} !== 2'b00 || s_dat !== 32'h0) begin
      errors++; $display("FAIL rst_mid outputs: got %b/%h expected 00/0", {s_ack, s_err}, s_dat);
    end
    checks++;
    if (u1.state_q !== ST_IDLE || u1.cnt_q !== 4'd0) begin
      errors++; $display("FAIL rst_mid state: got %0d/%0d expected IDLE/0", u1.state_q, u1.cnt_q);
    end
    bus_idle();
    #2 rst_ni = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      checks++;
      if ({s_ack, s_err} !== 2'b00) begin
        errors++; $display("FAIL rst_mid late term: got %b expected 00", {s_ack, s_err});
      end
    end
  endtask

  task automatic test_write_read();
    xfer(0, 1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, K_ACK, 0, 32'h0, 0, "wr_full");
    xfer(0, 1'b0, 32'h1000_0010, 4'hF, 32'h0,        K_ACK, 0, 32'h0, 0, "rd_full");
  endtask

  task automatic test_byte_lanes();
    xfer(0, 1'b1, 32'h1000_0020, 4'b1111, 32'h1122_3344, K_ACK, 0, 32'h0, 0, "lane_wr1");
    xfer(0, 1'b1, 32'h1000_0020, 4'b0101, 32'hAABB_CCDD, K_ACK, 0, 32'h0, 0, "lane_wr2");
    xfer(0, 1'b0, 32'h1000_0020, 4'b1111, 32'h0,         K_ACK, 0, 32'h0, 0, "lane_rd");
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 32'h1000_0040, 4'hF, 32'hCAFE_0001, K_ACK, 0, 32'h0, 0, "ws_wr_a");
    xfer(1, 1'b1, 32'h1000_0080, 4'hF, 32'h0BAD_F00D, K_ACK, 0, 32'h0, 0, "ws_wr_b");
    xfer(1, 1'b0, 32'h1000_0040, 4'hF, 32'h0,         K_ACK, 1, 32'h1000_0080, 0, "ws_rd_held");
  endtask

  task automatic test_out_of_window();
    xfer(0, 1'b1, 32'h1000_0000, 4'hF, 32'h5555_AAAA, K_ACK, 0, 32'h0, 0, "oow_seed");
    xfer(0, 1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0,         K_ERR, 0, 32'h0, 0, "oow_below");
    xfer(0, 1'b0, 32'h1000_4000, 4'hF, 32'h0,         K_ERR, 0, 32'h0, 0, "oow_above");
    xfer(0, 1'b1, 32'h1000_4000, 4'hF, 32'h1234_5678, K_ERR, 0, 32'h0, 0, "oow_wr");
    xfer(0, 1'b0, 32'h1000_0000, 4'hF, 32'h0,         K_ACK, 0, 32'h0, 0, "oow_ram_kept");
    xfer(2, 1'b0, 32'h0FFF_FFFC, 4'hF, 32'h0,         K_NONE, 0, 32'h0, 0, "noerr_below");
    xfer(2, 1'b0, 32'h1000_4000, 4'hF, 32'h0,         K_NONE, 0, 32'h0, 0, "noerr_above");
    xfer(2, 1'b1, 32'h1000_3FFC, 4'hF, 32'h7777_0001, K_ACK, 0, 32'h0, 0, "noerr_wr_top");
    xfer(2, 1'b0, 32'h1000_3FFC, 4'hF, 32'h0,         K_ACK, 0, 32'h0, 0, "noerr_rd_top");
  endtask

  task automatic test_abort();
    xfer(3, 1'b1, 32'h1000_0100, 4'hF, 32'h0000_00A5, K_NONE, 0, 32'h0, 2, "abort_wr");
    checks++;
    if (u3.state_q !== ST_IDLE) begin
      errors++; $display("FAIL abort state: got %0d expected IDLE", u3.state_q);
    end
    xfer(3, 1'b0, 32'h1000_0100, 4'hF, 32'h0, K_ACK, 0, 32'h0, 0, "abort_rd");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    for (int i = 0; i < 6; i++) begin
      a = BASE + 32'(($urandom_range(0, 4095)) << 2);
      d = $urandom;
      xfer(0, 1'b1, a, 4'(i + 9), d, K_ACK, 0, 32'h0, 0, "b2b_wr");
      xfer(0, 1'b0, a, 4'hF, 32'h0,  K_ACK, 0, 32'h0, 0, "b2b_rd");
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard residue: got %0d expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_write_read();
    test_byte_lanes();
    test_wait_states();
    test_out_of_window();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_wb_sram_slave

// File: doc/wb_sram_slave.md
# wb_sram_slave

Parametrised Wishbone classic slave fronting a single-port, byte-maskable synchronous RAM on the SoC bus. It is the successor of the fixed 16 KiB single-cycle memory slave and adds:

- configurable size and base address;
- programmable wait states via a small FSM;
- error termination for out-of-window accesses;
- abort handling when the master drops `cyc_i`;
- a non-tristated, zero-idle read bus.

It instantiates one RAM sub-module and sits beside the other slaves behind the SoC interconnect.

## Interface

Parameters:
- `BASE_ADDRESS`, 0: byte address of the first word; must be aligned to `SIZE_BYTES`.
- `SIZE_BYTES`, 16384: window size; power of two, minimum 4.
- `WAIT_STATES`, 0: extra cycles inserted before `ack_o`; legal range 0–15.
- `ERR_ENABLE`, 1: 1 = out-of-window strobes get `err_o`; 0 = they are ignored (the bus timeout handles them).

Ports:
- `clk_i` in 1: bus clock; the only clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `stb_i` in 1: strobe.
- `cyc_i` in 1: bus cycle valid.
- `adr_i` in 32: byte address; bits [1:0] are ignored.
- `sel_i` in 4: byte lane enables; bit n selects `dat_i[8n+7:8n]`.
- `dat_i` in 32: write data.
- `we_i` in 1: 1 = write.
- `dat_o` out 32: read data; valid only while `ack_o`=1, otherwise driven 0.
- `ack_o` out 1: normal termination, one-cycle pulse.
- `err_o` out 1: error termination, one-cycle pulse.
- `rty_o` out 1: tied 0.

## Operation

Definitions:
- `offset = adr_i − BASE_ADDRESS`.
- `hit = (adr_i ≥ BASE_ADDRESS) && (offset < SIZE_BYTES)`.
- Word index = `offset[AW+1:2]`, where `AW = $clog2(SIZE_BYTES/4)`.

FSM states are IDLE, WAIT, RESP and ERR.

IDLE:
- On `cyc_i & stb_i & hit`:
  - latch the word index, `we_i` and `sel_i`;
  - a write asserts the RAM write enable in this same cycle, with `sel_i` as the byte mask;
  - a read presents the address to the RAM;
  - load the wait counter with `WAIT_STATES`;
  - go to WAIT if `WAIT_STATES > 0`, else to RESP.
- On `cyc_i & stb_i & !hit & ERR_ENABLE`: go to ERR, with no RAM access.
- Otherwise stay in IDLE.

WAIT:
- Decrement the counter each cycle.
- Go to RESP on the cycle the counter reaches 1.
- The RAM address stays held from the latched copy, so `adr_i` may change.

RESP:
- `ack_o` = 1.
- `dat_o` = RAM read data for reads; 0 for writes.
- Next state is IDLE unconditionally. Back-to-back strobes are therefore separated by at least one IDLE cycle, and each strobe is acknowledged exactly once.

ERR:
- `err_o` = 1 for one cycle, then go to IDLE.

Abort:
- If `cyc_i` = 0 in WAIT, go to IDLE with no termination.
- A write committed at acceptance stays committed.
- The RAM is never written outside IDLE.

`ack_o` and `err_o` are never high together.

## Timing

- Reset (`rst_ni` low, asynchronous): state = IDLE, counter = 0, `ack_o` = `err_o` = `rty_o` = 0, `dat_o` = 0.
- Reset asserted mid-transfer aborts the transfer with no termination. RAM contents are not cleared.
- Let cycle 0 be the cycle a strobe is accepted in IDLE. Then `ack_o` is high in cycle `1 + WAIT_STATES`, and `err_o` is high in cycle 1.
- RAM read latency is one cycle from the registered address. `dat_o` is combinational from the RAM output, gated by RESP.
- Minimum strobe-to-strobe throughput is one transfer per `2 + WAIT_STATES` cycles.
- A write becomes visible to a read accepted in the cycle after acceptance or later.

## Structure

- Shared `soc_pkg` holds the Wishbone data/address width constants (32) and the FSM state encoding `wb_slave_state_t`, which is reused by future slaves.
- Sub-module `sram_sp`, parameter `WORDS`:
  - behavioural single-port RAM with a 4-bit byte write mask;
  - registered read;
  - ports `clk_i`, `we_i`, `be_i`, `addr_i`, `wdata_i`, `rdata_o`;
  - swappable for the iCE40 SPRAM primitive when `SIZE_BYTES` = 16384.
- The top level holds only the FSM, the counter, the decode logic and the output gating.

## Test plan

- Reset/idle:
  - stimulus: reset pulsed low mid-WAIT;
  - required: `ack_o`/`err_o`/`dat_o` go 0 immediately, state is IDLE, no ack after release.
- Full-word write then read, `WAIT_STATES` = 0, `BASE_ADDRESS` = 0x1000_0000:
  - stimulus: write 0xDEADBEEF at 0x1000_0010, then read the same address;
  - required: ack in cycle 1 of each transfer; read `dat_o` = 0xDEADBEEF; `dat_o` = 0 in every non-ack cycle.
- Byte lanes:
  - stimulus: write 0x11223344 with `sel_i` = 4'b1111, then 0xAABBCCDD with `sel_i` = 4'b0101;
  - required: read returns 0x11BB33DD.
- Wait states, `WAIT_STATES` = 3:
  - stimulus: read accepted in cycle 0, with `adr_i` changed to garbage in cycle 1;
  - required: `ack_o` only in cycle 4, with data from the original address.
- Out of window:
  - stimulus, `ERR_ENABLE` = 1: read 0x0FFF_FFFC and 0x1000_4000;
  - required: `err_o` in cycle 1, no ack, RAM unchanged;
  - stimulus, `ERR_ENABLE` = 0: the same reads;
  - required: no response for 20 cycles.
- Abort, `WAIT_STATES` = 5:
  - stimulus: write 0x0000_00A5, drop `cyc_i` in cycle 2;
  - required: no ack; FSM returns to IDLE; a later read returns 0x0000_00A5.
